counter_fixture: RTL and testbench
==================================

COUNTER_FIXTURE -- requirements
Module: counter_fixture

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal 1..64.
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1: terminal count; legal 1..2**WIDTH-1.
REQ-003 Parameter RESET_VALUE, default 0: value loaded by reset and clear; legal 0..MAX_VALUE.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 async_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 sync_clr  input  1  synchronous clear of count and sticky flags.
REQ-008 en  input  1  count enable.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-010 load  input  1  synchronous load request.
REQ-011 load_value  input  WIDTH  value for load.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 at_max  output  1  combinational, count==MAX_VALUE.
REQ-014 at_zero  output  1  combinational, count==0.
REQ-015 wrap_pulse  output  1  registered one-cycle pulse after a boundary event.
REQ-016 ovf_sticky  output  1  registered; set by an upward boundary event, held until cleared.
REQ-017 unf_sticky  output  1  registered; set by a downward boundary event, held until cleared.

Function
REQ-018 Per-edge priority: sync_clr > load > en; only the highest-priority active request takes effect.
REQ-019 sync_clr=1: count<=RESET_VALUE; ovf_sticky, unf_sticky, wrap_pulse <= 0.
REQ-020 load=1 (sync_clr=0): count<=load_value if load_value<=MAX_VALUE, else MAX_VALUE (clamp); sticky flags unchanged; wrap_pulse<=0.
REQ-021 en=1, up=1, count<MAX_VALUE: count<=count+1.
REQ-022 en=1, up=1, count==MAX_VALUE (upward boundary event): count<=0 if SATURATE=0, else count holds at MAX_VALUE; ovf_sticky<=1; wrap_pulse<=1.
REQ-023 en=1, up=0, count>0: count<=count-1.
REQ-024 en=1, up=0, count==0 (downward boundary event): count<=MAX_VALUE if SATURATE=0, else count holds at 0; unf_sticky<=1; wrap_pulse<=1.
REQ-025 No request active: count and sticky flags hold; wrap_pulse<=0.
REQ-026 wrap_pulse is high exactly one cycle per boundary event; back-to-back boundary events (e.g. saturated and en held) keep it high on each consecutive cycle.
REQ-027 Arithmetic is unsigned, WIDTH bits; count never takes a value above MAX_VALUE.
REQ-028 at_max and at_zero follow count within the same cycle, with no register stage.

Reset
REQ-029 async_rst_n=0 immediately forces count=RESET_VALUE and ovf_sticky=unf_sticky=wrap_pulse=0, without waiting for a clock edge.
REQ-030 Reset assertion mid-count overrides all inputs; state holds at reset values while async_rst_n=0.
REQ-031 Deassertion is synchronous to clk externally; the first counting edge is the first rising clk edge after async_rst_n=1.

Verification
REQ-032 WIDTH=8, defaults, en=1 up=1 for 256 edges from reset -> count 0..255 then 0; wrap_pulse high exactly once, the cycle after count=255; ovf_sticky=1 from then on.
REQ-033 MAX_VALUE=9, SATURATE=0, en=1 up=0 from 0 -> count 9,8,..,0,9; unf_sticky=1 after the first edge; at_zero high while count=0.
REQ-034 MAX_VALUE=9, SATURATE=1, en=1 up=1 from 7 for 5 edges -> count 8,9,9,9,9; wrap_pulse high on the 3rd, 4th and 5th cycles.
REQ-035 load=1, load_value=200, MAX_VALUE=100 -> count=100 next edge; sync_clr=1 with load=1 and en=1 -> count=RESET_VALUE and stickies cleared.
REQ-036 async_rst_n pulsed low for half a cycle mid-count at count=0x37 -> count=RESET_VALUE before the next edge; counting resumes from RESET_VALUE after release.
REQ-037 Random en/up/load/sync_clr for 10k cycles against a reference model -> count and all flags match every cycle.

Source files
------------

// File: rtl/counter_fixture_if.sv
// counter_fixture_if: control inputs and status outputs of counter_fixture.
// master drives the requests, slave is the counter itself.
interface counter_fixture_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sync_clr;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrap_pulse;
    logic             ovf_sticky;
    logic             unf_sticky;

    modport master (
        output sync_clr,
        output en,
        output up,
        output load,
        output load_value,
        input  count,
        input  at_max,
        input  at_zero,
        input  wrap_pulse,
        input  ovf_sticky,
        input  unf_sticky
    );

    modport slave (
        input  sync_clr,
        input  en,
        input  up,
        input  load,
        input  load_value,
        output count,
        output at_max,
        output at_zero,
        output wrap_pulse,
        output ovf_sticky,
        output unf_sticky
    );
endinterface

// File: rtl/counter_fixture.sv
// counter_fixture: up/down counter with a terminal count, clamp-on-load,
// wrap or saturate at the boundaries, and sticky overflow/underflow flags.
module counter_fixture #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input logic              clk,
    input logic              async_rst_n,
    counter_fixture_if.slave bus
);

    typedef logic [WIDTH-1:0] cnt_t;

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;
    logic wrap_q;
    logic wrap_d;

    logic hit_max;
    logic hit_zero;
    cnt_t load_clamped;

    logic do_clr;
    logic do_load;
    logic do_inc;
    logic do_dec;

    assign hit_max  = (cnt_q == MAX_VALUE);
    assign hit_zero = (cnt_q == '0);

    assign load_clamped = (bus.load_value > MAX_VALUE)
                        ? MAX_VALUE : bus.load_value;

    // One-hot request decode: clear beats load beats count.
    assign do_clr  = bus.sync_clr;
    assign do_load = ~bus.sync_clr & bus.load;
    assign do_inc  = ~bus.sync_clr & ~bus.load & bus.en & bus.up;
    assign do_dec  = ~bus.sync_clr & ~bus.load & bus.en & ~bus.up;

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wrap_d = 1'b0;
        unique case (1'b1)
            do_clr: begin
                cnt_d = RESET_VALUE;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            do_load: begin
                cnt_d = load_clamped;
            end
            do_inc: begin
                if (hit_max) begin
                    cnt_d  = SATURATE ? MAX_VALUE : '0;
                    ovf_d  = 1'b1;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            do_dec: begin
                if (hit_zero) begin
                    cnt_d  = SATURATE ? cnt_t'(0) : MAX_VALUE;
                    unf_d  = 1'b1;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt_q  <= RESET_VALUE;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.count      = cnt_q;
    assign bus.at_max     = hit_max;
    assign bus.at_zero    = hit_zero;
    assign bus.wrap_pulse = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.unf_sticky = unf_q;

endmodule

// File: tb/tb_counter_fixture.sv
// tb_counter_fixture: directed and randomized checks of counter_fixture
// across wrap, saturate and clamped-load configurations.
module tb_counter_fixture;

    logic clk;
    logic async_rst_n;

    int n_checks;
    int n_errors;

    counter_fixture_if #(.WIDTH(8)) b0 ();
    counter_fixture_if #(.WIDTH(8)) b1 ();
    counter_fixture_if #(.WIDTH(8)) b2 ();
    counter_fixture_if #(.WIDTH(8)) b3 ();

    // b0: defaults (0..255, wrap)
    counter_fixture #(
        .WIDTH(8)
    ) u0 (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .bus(b0.slave)
    );

    // b1: 0..9, wrap
    counter_fixture #(
        .WIDTH(8),
        .MAX_VALUE(8'd9),
        .RESET_VALUE(8'd0),
        .SATURATE(1'b0)
    ) u1 (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .bus(b1.slave)
    );

    // b2: 0..9, saturate
    counter_fixture #(
        .WIDTH(8),
        .MAX_VALUE(8'd9),
        .RESET_VALUE(8'd0),
        .SATURATE(1'b1)
    ) u2 (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .bus(b2.slave)
    );

    // b3: 0..100, reset to 5, wrap
    counter_fixture #(
        .WIDTH(8),
        .MAX_VALUE(8'd100),
        .RESET_VALUE(8'd5),
        .SATURATE(1'b0)
    ) u3 (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .bus(b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_step(input int mx, input bit sat, input int rv,
                            input bit clr, input bit ld, input int lv,
                            input bit e, input bit u,
                            inout int c, inout bit o, inout bit n,
                            output bit w);
        w = 1'b0;
        if (clr) begin
            c = rv;
            o = 1'b0;
            n = 1'b0;
        end else if (ld) begin
            c = (lv > mx) ? mx : lv;
        end else if (e && u) begin
            if (c == mx) begin
                c = sat ? mx : 0;
                o = 1'b1;
                w = 1'b1;
            end else begin
                c = c + 1;
            end
        end else if (e) begin
            if (c == 0) begin
                c = sat ? 0 : mx;
                n = 1'b1;
                w = 1'b1;
            end else begin
                c = c - 1;
            end
        end
    endtask

    task automatic idle_all();
        b0.sync_clr = 0; b0.en = 0; b0.up = 0; b0.load = 0; b0.load_value = 0;
        b1.sync_clr = 0; b1.en = 0; b1.up = 0; b1.load = 0; b1.load_value = 0;
        b2.sync_clr = 0; b2.en = 0; b2.up = 0; b2.load = 0; b2.load_value = 0;
        b3.sync_clr = 0; b3.en = 0; b3.up = 0; b3.load = 0; b3.load_value = 0;
    endtask

    int  mx  [2] = '{9, 100};
    bit  sat [2] = '{1'b1, 1'b0};
    int  rv  [2] = '{0, 5};
    int  mc  [2];
    bit  mo  [2];
    bit  mn  [2];
    bit  mw  [2];

    initial begin
        int exp_c;
        int e_seq [5];
        bit w_seq [5];
        bit clr;
        bit ld;
        bit e;
        bit u;
        int lv;

        n_checks = 0;
        n_errors = 0;
        idle_all();
        async_rst_n = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cnt0", b0.count, 0);
        check("rst_cnt3", b3.count, 5);
        check("rst_ovf0", b0.ovf_sticky, 0);
        check("rst_unf0", b0.unf_sticky, 0);
        check("rst_wrap0", b0.wrap_pulse, 0);
        check("rst_zero0", b0.at_zero, 1);
        check("rst_zero3", b3.at_zero, 0);
        async_rst_n = 1'b1;

        // Full 8-bit wrap
        b0.en = 1; b0.up = 1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            exp_c = k % 256;
            check("up8_cnt", b0.count, exp_c);
            check("up8_wrap", b0.wrap_pulse, (k == 256) ? 1 : 0);
            check("up8_ovf", b0.ovf_sticky, (k == 256) ? 1 : 0);
            check("up8_max", b0.at_max, (k == 255) ? 1 : 0);
        end
        b0.en = 0;
        tick();
        check("up8_hold_cnt", b0.count, 0);
        check("up8_hold_wrap", b0.wrap_pulse, 0);
        check("up8_hold_ovf", b0.ovf_sticky, 1);

        // Down-count wrap with MAX_VALUE=9
        b1.en = 1; b1.up = 0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            exp_c = (j == 11) ? 9 : 10 - j;
            check("dn9_cnt", b1.count, exp_c);
            check("dn9_unf", b1.unf_sticky, 1);
            check("dn9_wrap", b1.wrap_pulse,
                  (j == 1 || j == 11) ? 1 : 0);
            check("dn9_zero", b1.at_zero, (exp_c == 0) ? 1 : 0);
        end
        b1.en = 0;

        // Saturating up-count from 7
        b2.load = 1; b2.load_value = 7;
        tick();
        check("sat_load", b2.count, 7);
        b2.load = 0; b2.en = 1; b2.up = 1;
        e_seq = '{8, 9, 9, 9, 9};
        w_seq = '{0, 0, 1, 1, 1};
        for (int j = 0; j < 5; j++) begin
            tick();
            check("sat_cnt", b2.count, e_seq[j]);
            check("sat_wrap", b2.wrap_pulse, w_seq[j]);
        end
        check("sat_ovf", b2.ovf_sticky, 1);
        b2.en = 0;
        tick();
        check("sat_idle_wrap", b2.wrap_pulse, 0);

        // Clamped load, then clear over load and en
        b3.load = 1; b3.load_value = 200;
        tick();
        check("clamp_cnt", b3.count, 100);
        check("clamp_max", b3.at_max, 1);
        b3.load = 0; b3.en = 1; b3.up = 1;
        tick();
        check("c100_wrap_cnt", b3.count, 0);
        check("c100_wrap", b3.wrap_pulse, 1);
        check("c100_ovf", b3.ovf_sticky, 1);
        b3.sync_clr = 1; b3.load = 1; b3.load_value = 50;
        tick();
        check("clr_cnt", b3.count, 5);
        check("clr_ovf", b3.ovf_sticky, 0);
        check("clr_wrap", b3.wrap_pulse, 0);
        b3.sync_clr = 0; b3.load = 1; b3.load_value = 8'h37; b3.en = 0;
        tick();
        check("ld37", b3.count, 8'h37);
        b3.load = 0; b3.en = 1; b3.up = 1;
        tick();
        check("cnt38", b3.count, 8'h38);

        // Asynchronous reset pulse mid-count
        async_rst_n = 1'b0;
        #2;
        check("arst_cnt", b3.count, 5);
        check("arst_ovf0", b0.ovf_sticky, 0);
        #3;
        async_rst_n = 1'b1;
        tick();
        check("arst_resume", b3.count, 6);
        idle_all();

        // Randomized run against the reference model (b2 sat, b3 wrap)
        async_rst_n = 1'b0;
        tick();
        async_rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mc[k] = rv[k];
            mo[k] = 1'b0;
            mn[k] = 1'b0;
            mw[k] = 1'b0;
        end
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < 2; k++) begin
                clr = ($urandom_range(0, 31) == 0);
                ld  = ($urandom_range(0, 15) == 0);
                e   = ($urandom_range(0, 3) != 0);
                u   = $urandom_range(0, 1) != 0;
                lv  = (k == 0) ? $urandom_range(0, 15)
                               : $urandom_range(0, 255);
                if (k == 0) begin
                    b2.sync_clr = clr; b2.load = ld;
                    b2.load_value = 8'(lv); b2.en = e; b2.up = u;
                end else begin
                    b3.sync_clr = clr; b3.load = ld;
                    b3.load_value = 8'(lv); b3.en = e; b3.up = u;
                end
                ref_step(mx[k], sat[k], rv[k], clr, ld, lv, e, u,
                         mc[k], mo[k], mn[k], mw[k]);
            end
            tick();
            check("rnd2_cnt", b2.count, mc[0]);
            check("rnd2_wrap", b2.wrap_pulse, mw[0]);
            check("rnd2_ovf", b2.ovf_sticky, mo[0]);
            check("rnd2_unf", b2.unf_sticky, mn[0]);
            check("rnd2_max", b2.at_max, (mc[0] == mx[0]) ? 1 : 0);
            check("rnd2_zero", b2.at_zero, (mc[0] == 0) ? 1 : 0);
            check("rnd3_cnt", b3.count, mc[1]);
            check("rnd3_wrap", b3.wrap_pulse, mw[1]);
            check("rnd3_ovf", b3.ovf_sticky, mo[1]);
            check("rnd3_unf", b3.unf_sticky, mn[1]);
            check("rnd3_max", b3.at_max, (mc[1] == mx[1]) ? 1 : 0);
            check("rnd3_zero", b3.at_zero, (mc[1] == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
